uart_rx: RTL and testbench

UART receive controller, the counterpart of the existing UART transmit path. Oversamples the serial line RX_IN by a run-time prescale and recovers start, data, optional parity and stop bits by majority vote. Deserialises LSB-first data into P_DATA and checks parity and stop bits. Sits between the external RX pin (already synchronised upstream) and the RX data-sync/register-file side of the system.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx_sampler.sv | 41 ++++
 rtl/uart_rx.sv | 97 +++++++++
 tb/tb_uart_rx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int PRESC_8        = 8;
  localparam int PRESC_16       = 16;
  localparam int PRESC_32       = 32;
  localparam int DEF_DATA_WIDTH = 8;

  // Unsupported oversampling ratios fall back to x8.
  function automatic int presc_norm(input int p);
    return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and received-data signals of the UART receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  BUSY;

  modport master (output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
                  input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY);
  modport slave  (input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
                  output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY);
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with a three-sample majority vote around mid-bit.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx,
  input  logic                  run,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] presc,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  bit_end
);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic [2:0]            samp;

  assign half         = presc >> 1;
  assign bit_end      = (edge_cnt == presc - ONE);
  assign sample_valid = (edge_cnt >= half + TWO);
  assign sampled_bit  = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      samp     <= '0;
    end else begin
      if (clr)      edge_cnt <= '0;
      else if (run) edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
      if (run) begin
        if (edge_cnt == half - ONE) samp[0] <= rx;
        if (edge_cnt == half)       samp[1] <= rx;
        if (edge_cnt == half + ONE) samp[2] <= rx;
      end
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first deserialiser, parity and stop checks.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESCALE_W = 6
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);
  localparam int                BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]     LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0]     BONE = BW'(1);

  rx_state_t             state;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  par_en_q, par_typ_q, par_fail;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] sr;
  logic                  sampled_bit, sample_valid, bit_end;
  logic                  run, glitch;

  // The detection cycle in IDLE already counts as edge 0 of the start bit.
  assign run    = (state != IDLE) || !bus.RX_IN;
  assign glitch = (state == START) && sample_valid && sampled_bit;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .rx           (bus.RX_IN),
    .run          (run),
    .clr          (glitch),
    .presc        (presc_q),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .bit_end      (bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      presc_q        <= PRESCALE_W'(PRESC_8);
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      par_fail       <= 1'b0;
      bit_cnt        <= '0;
      sr             <= '0;
      bus.P_DATA     <= '0;
      bus.DATA_VALID <= 1'b0;
      bus.PAR_ERR    <= 1'b0;
      bus.STP_ERR    <= 1'b0;
      bus.BUSY       <= 1'b0;
    end else begin
      bus.DATA_VALID <= 1'b0;
      case (state)
        IDLE: if (!bus.RX_IN) begin
          state       <= START;
          bus.BUSY    <= 1'b1;
          presc_q     <= PRESCALE_W'(presc_norm(int'(bus.PRESCALE)));
          par_en_q    <= bus.PAR_EN;
          par_typ_q   <= bus.PAR_TYP;
          par_fail    <= 1'b0;
          bit_cnt     <= '0;
          bus.PAR_ERR <= 1'b0;
          bus.STP_ERR <= 1'b0;
        end
        START: begin
          if (glitch) begin
            state    <= IDLE;
            bus.BUSY <= 1'b0;
          end else if (bit_end) state <= DATA;
        end
        DATA: if (bit_end) begin
          sr <= {sampled_bit, sr[DATA_WIDTH-1:1]};
          if (bit_cnt == LAST) state <= par_en_q ? PARITY : STOP;
          else                 bit_cnt <= bit_cnt + BONE;
        end
        PARITY: if (bit_end) begin
          par_fail <= (sampled_bit != (^sr ^ par_typ_q));
          state    <= STOP;
        end
        STOP: if (bit_end) begin
          bus.PAR_ERR <= par_fail;
          bus.STP_ERR <= !sampled_bit;
          if (!par_fail && sampled_bit) begin
            bus.P_DATA     <= sr;
            bus.DATA_VALID <= 1'b1;
          end
          state    <= IDLE;
          bus.BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level model checked every cycle plus literal pins.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus();
  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One record per frame: f = cycle the line first reads low, e = cycle outputs update.
  typedef struct {
    int f; int e; int be; bit glitch; bit good; logic [7:0] d; bit pe; bit se;
  } frm_t;
  frm_t q[$];

  logic [7:0] m_pdata = '0;
  bit m_perr = 0, m_serr = 0, chk_en = 0;
  int dv_cnt = 0, last_dv = 0, busy_cnt = 0;

  always @(negedge clk) if (chk_en) begin
    bit xdv, xbusy;
    while (q.size() > 0 && q[0].e < cyc) q.delete(0);
    xdv = 0; xbusy = 0;
    foreach (q[i]) begin
      if (cyc == q[i].f + 1) begin m_perr = 0; m_serr = 0; end
      if (cyc > q[i].f && cyc <= q[i].be) xbusy = 1;
      if (!q[i].glitch && cyc == q[i].e) begin
        m_perr = q[i].pe; m_serr = q[i].se;
        if (q[i].good) begin m_pdata = q[i].d; xdv = 1; end
      end
    end
    chk("DATA_VALID", bus.DATA_VALID, xdv);
    chk("BUSY",       bus.BUSY,       xbusy);
    chk("P_DATA",     bus.P_DATA,     m_pdata);
    chk("PAR_ERR",    bus.PAR_ERR,    m_perr);
    chk("STP_ERR",    bus.STP_ERR,    m_serr);
    if (bus.DATA_VALID) begin dv_cnt++; last_dv = cyc; end
    if (bus.BUSY) busy_cnt++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " P_DATA"},     bus.P_DATA,     0);
    chk({tag, " DATA_VALID"}, bus.DATA_VALID, 0);
    chk({tag, " PAR_ERR"},    bus.PAR_ERR,    0);
    chk({tag, " STP_ERR"},    bus.STP_ERR,    0);
    chk({tag, " BUSY"},       bus.BUSY,       0);
  endtask

  // Called mid-cycle: reset must clear outputs without waiting for a clock edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1 chk_zero("async_rst");
    q.delete();
    m_pdata = '0; m_perr = 0; m_serr = 0;
    bus.RX_IN = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(2);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                            input bit bad_par, input bit bad_stop, input int rst_at,
                            input bit mess);
    logic [10:0] bits;
    frm_t r;
    int pf, n;
    pf = (p == 16 || p == 32) ? p : 8;
    n  = 10 + int'(pen);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pen) bits[9] = ^d ^ ptyp ^ bad_par;
    bits[n-1] = !bad_stop;
    bus.PRESCALE = 6'(p); bus.PAR_EN = pen; bus.PAR_TYP = ptyp;
    r.f = cyc; r.e = cyc + n * pf; r.be = r.e - 1; r.glitch = 0; r.d = d;
    r.pe = pen && bad_par; r.se = bad_stop; r.good = !r.pe && !r.se;
    q.push_back(r);
    for (int b = 0; b < n; b++) begin
      bus.RX_IN = bits[b];
      if (b == 2 && mess) begin bus.PRESCALE = 6'd16; bus.PAR_EN = !pen; bus.PAR_TYP = !ptyp; end
      for (int j = 0; j < pf; j++) begin
        if (b == rst_at && j == 3) begin do_reset(); return; end
        step();
      end
    end
    bus.RX_IN = 1'b1;
    bus.PRESCALE = 6'(p); bus.PAR_EN = pen; bus.PAR_TYP = ptyp;
  endtask

  task automatic send_glitch(input int low_cycles);
    frm_t r;
    bus.PRESCALE = 6'd8;
    r.f = cyc; r.be = cyc + 8 / 2 + 2; r.e = r.be + 1; r.glitch = 1;
    r.good = 0; r.d = '0; r.pe = 0; r.se = 0;
    q.push_back(r);
    busy_cnt = 0;
    bus.RX_IN = 1'b0;
    idle(low_cycles);
    bus.RX_IN = 1'b1;
  endtask

  int f0, f1;
  initial begin
    bus.RX_IN = 1'b1; bus.PRESCALE = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    idle(3);
    chk_zero("reset");
    rst = 1'b1;
    step();
    chk_en = 1;
    idle(4);

    // 0xA5, x8, even parity
    f0 = cyc;
    send_frame(8'hA5, 8, 1, 0, 0, 0, -1, 0);
    idle(4);
    chk("a5 latency", last_dv - f0, 88);
    chk("a5 data", bus.P_DATA, 8'hA5);
    chk("a5 dv count", dv_cnt, 1);

    // 0x3C, x16, odd parity, wrong parity bit
    send_frame(8'h3C, 16, 1, 1, 1, 0, -1, 0);
    idle(4);
    chk("par_err flag", bus.PAR_ERR, 1);
    chk("par_err data kept", bus.P_DATA, 8'hA5);
    chk("par_err no dv", dv_cnt, 1);

    // 0x5A, x8, no parity, stop bit low; then 0x11 with mid-frame config churn
    send_frame(8'h5A, 8, 0, 0, 0, 1, -1, 0);
    idle(4);
    chk("stp_err flag", bus.STP_ERR, 1);
    chk("stp_err par clear", bus.PAR_ERR, 0);
    chk("stp_err no dv", dv_cnt, 1);
    send_frame(8'h11, 8, 0, 0, 0, 0, -1, 1);
    idle(4);
    chk("11 data", bus.P_DATA, 8'h11);
    chk("11 stp cleared", bus.STP_ERR, 0);

    // unsupported prescale behaves as x8
    f0 = cyc;
    send_frame(8'h6B, 12, 0, 0, 0, 0, -1, 0);
    idle(4);
    chk("presc12 latency", last_dv - f0, 80);
    chk("presc12 data", bus.P_DATA, 8'h6B);

    // two-cycle glitch
    send_glitch(2);
    idle(20);
    chk("glitch busy cycles", busy_cnt, 6);
    chk("glitch no dv", dv_cnt, 3);

    // back-to-back x32 frames
    f0 = cyc;
    send_frame(8'hFF, 32, 0, 0, 0, 0, -1, 0);
    f1 = cyc;
    send_frame(8'h00, 32, 0, 0, 0, 0, -1, 0);
    idle(4);
    chk("b2b gap", f1 - f0, 320);
    chk("b2b latency", last_dv - f1, 320);
    chk("b2b data", bus.P_DATA, 8'h00);
    chk("b2b dv count", dv_cnt, 5);

    // reset during data bit 4, then a clean frame
    send_frame(8'hC3, 8, 0, 0, 0, 0, 5, 0);
    chk("post-rst dv count", dv_cnt, 5);
    send_frame(8'h81, 8, 0, 0, 0, 0, -1, 0);
    idle(4);
    chk("81 data", bus.P_DATA, 8'h81);
    chk("81 dv count", dv_cnt, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
